mca_scheduler: RTL

Controls the shared multi-cycle adder (MCA) in the downsampled FIR estimator. Up to NUM_REQ requesters, such as lookahead and lookback coefficient banks, compete for one MCA. The block arbitrates between them, selects the winner's operand vector through an external mux, and pulses the MCA start. It then counts the MCA latency in enabled cycles, captures the sum, and returns it tagged with the requester ID. It sits between the FIR control logic and the single MCA instance.

---
 rtl/mca_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mca_scheduler.sv
// Arbiter and sequencer that shares one multi-cycle adder among NUM_REQ requesters.
// Define MCA_SCHED_RR_EN for round-robin arbitration; otherwise the lowest index has fixed priority.
module mca_scheduler #(
  parameter int NUM_REQ           = 4,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int MCA_LATENCY       = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic        [NUM_REQ-1:0]           req,
  output logic        [NUM_REQ-1:0]           grant,
  output logic        [$clog2(NUM_REQ)-1:0]   mca_sel,
  output logic                                mca_start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] mca_res,
  output logic signed [WIDTH_COEFFICIENT-1:0] res,
  output logic        [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                                res_valid,
  output logic                                busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(MCA_LATENCY) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MCA_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t             state, state_d;
  logic [TMR_W-1:0]   timer;
  logic [NUM_REQ-1:0] cand;
  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_load, grant_clr, cap, tmr_clr, tmr_inc;

`ifdef MCA_SCHED_RR_EN
  logic [IDX_W-1:0]   ptr;
`endif

  // Arbitration: scan downward so the last hit written is the highest-priority one.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cand    = req;
    arb_hit = 1'b0;
    arb_idx = '0;
`ifdef MCA_SCHED_RR_EN
    if (state == CAPTURE) cand[mca_sel] = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[IDX_W'((int'(ptr) + i) % NUM_REQ)]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[IDX_W'(i)]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d   = state;
    arb_load  = 1'b0;
    grant_clr = 1'b0;
    cap       = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_hit) begin
          arb_load = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        tmr_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_inc = 1'b1;
        if (timer == TMR_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        cap = 1'b1;
        if (arb_hit) begin
          arb_load = 1'b1;
          state_d  = ISSUE;
        end else begin
          grant_clr = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mca_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  // Everything advances only on downsample-enabled edges, in lockstep with the MCA.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      timer     <= '0;
      grant     <= '0;
      mca_sel   <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
`ifdef MCA_SCHED_RR_EN
      ptr       <= '0;
`endif
    end else if (enable) begin
      // NOTE: non-blocking assignments let res_id take the old mca_sel while a new winner loads.
      state     <= state_d;
      res_valid <= cap;
      if (cap) begin
        res    <= mca_res;
        res_id <= mca_sel;
      end
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
      if (arb_load) begin
        grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
        mca_sel <= arb_idx;
`ifdef MCA_SCHED_RR_EN
        ptr     <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
      end else if (grant_clr) begin
        grant <= '0;
      end
    end
  end

endmodule
